seq_detector_prog: RTL and testbench

Programmable serial bit-pattern detector; the parametrised successor of the fixed 5-bit Moore sequence recogniser. Pattern, length and overlap mode are loaded at run time. A registered match pulse is produced for each detection, and a saturating match counter with a sticky overflow flag tracks detections. It sits on a 1-bit serial input stream gated by a sample-enable.

---
 rtl/seq_det_pkg.sv | 23 ++
 rtl/sat_counter.sv | 33 +++
 rtl/seq_detector_prog.sv | 95 +++++++++
 tb/tb_seq_detector_prog.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared constants and the length-masked pattern compare for the programmable
// serial sequence detector.
package seq_det_pkg;

  localparam int DEF_MAX_LEN = 8;
  localparam int DEF_CNT_W   = 8;
  localparam int DEF_LEN_W   = $clog2(DEF_MAX_LEN + 1);
  // Widest pattern the compare helper supports; callers zero-extend into it.
  localparam int CMP_W       = 64;

  // True when the low 'len' bits of a and b agree; bits at or above len are ignored.
  function automatic logic masked_eq(input logic [CMP_W-1:0] a,
                                     input logic [CMP_W-1:0] b,
                                     input int               len);
    logic eq;
    eq = 1'b1;
    for (int i = 0; i < CMP_W; i++) begin
      if ((i < len) && (a[i] != b[i])) eq = 1'b0;
    end
    return eq;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with a sticky overflow flag; clear wins over
// accumulation but an increment in the same cycle still lands as a count of one.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count,
  output logic         sat
);

  logic [W-1:0] r_count;
  logic         r_sat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
      r_sat   <= 1'b0;
    end else if (clr) begin
      r_count <= inc ? W'(1) : '0;
      r_sat   <= 1'b0;
    end else if (inc) begin
      if (&r_count) r_sat <= 1'b1;
      else          r_count <= r_count + W'(1);
    end
  end

  assign count = r_count;
  assign sat   = r_sat;

endmodule

// File: rtl/seq_detector_prog.sv
// Programmable serial bit-pattern detector: run-time pattern/length/overlap,
// registered match pulse and a saturating match counter.
module seq_detector_prog
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           load,
  input  logic [MAX_LEN-1:0]             cfg_pattern,
  input  logic [$clog2(MAX_LEN+1)-1:0]   cfg_len,
  input  logic                           cfg_overlap,
  input  logic                           en,
  input  logic                           x,
  input  logic                           clear,
  output logic                           u,
  output logic [CNT_W-1:0]               match_count,
  output logic                           sat,
  output logic                           armed,
  output logic                           cfg_err
);

  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

  logic [MAX_LEN-1:0] r_hist;
  logic [LEN_W-1:0]   r_fill;
  logic [MAX_LEN-1:0] r_pat;
  logic [LEN_W-1:0]   r_len;
  logic               r_ovl;
  logic               r_armed;
  logic               r_err;
  logic               r_u;

  logic [MAX_LEN-1:0] w_hist_n;
  logic [LEN_W-1:0]   w_fill_n;
  logic               w_sample;
  logic               w_hit;
  logic               w_cfg_ok;

  assign w_cfg_ok = (cfg_len != '0) && (cfg_len <= LEN_MAX);
  assign w_sample = en && r_armed && !load;
  // hist[0] is always the newest bit, so the pattern's last bit lines up with bit 0.
  assign w_hist_n = {r_hist[MAX_LEN-2:0], x};
  assign w_fill_n = (r_fill == LEN_MAX) ? r_fill : r_fill + LEN_W'(1);
  assign w_hit    = w_sample && (w_fill_n >= r_len) &&
                    masked_eq(CMP_W'(w_hist_n), CMP_W'(r_pat), int'(r_len));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hist  <= '0;
      r_fill  <= '0;
      r_pat   <= '0;
      r_len   <= '0;
      r_ovl   <= 1'b0;
      r_armed <= 1'b0;
      r_err   <= 1'b0;
      r_u     <= 1'b0;
    end else if (load) begin
      r_pat   <= cfg_pattern;
      r_len   <= cfg_len;
      r_ovl   <= cfg_overlap;
      r_armed <= w_cfg_ok;
      r_err   <= !w_cfg_ok;
      r_hist  <= '0;
      r_fill  <= '0;
      r_u     <= 1'b0;
    end else begin
      r_u <= w_hit;
      if (w_sample) begin
        r_hist <= w_hist_n;
        // Non-overlapping mode restarts the history so matched bits are not reused.
        r_fill <= (w_hit && !r_ovl) ? '0 : w_fill_n;
      end
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_hit),
    .clr   (clear && !load),
    .count (match_count),
    .sat   (sat)
  );

  assign u       = r_u;
  assign armed   = r_armed;
  assign cfg_err = r_err;

endmodule

// File: tb/tb_seq_detector_prog.sv
// Directed bench for seq_detector_prog (MAX_LEN=8, CNT_W=2) with hand-computed expectations.
module tb_seq_detector_prog;

  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 2;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);

  logic               clk = 1'b0;
  logic               rst;
  logic               load;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic               en;
  logic               x;
  logic               clear;
  logic               u;
  logic [CNT_W-1:0]   match_count;
  logic               sat;
  logic               armed;
  logic               cfg_err;

  int n_tests = 0;
  int n_fail  = 0;

  seq_detector_prog #(
    .MAX_LEN(MAX_LEN),
    .CNT_W  (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .en          (en),
    .x           (x),
    .clear       (clear),
    .u           (u),
    .match_count (match_count),
    .sat         (sat),
    .armed       (armed),
    .cfg_err     (cfg_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_load(input logic [MAX_LEN-1:0] pat, input logic [LEN_W-1:0] len,
                         input logic ovl);
    load = 1'b1; cfg_pattern = pat; cfg_len = len; cfg_overlap = ovl;
    @(posedge clk); #1;
    load = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
  endtask

  // Sample one bit and check the registered match pulse one edge later.
  task automatic send(input logic b, input logic exp_u, input string tag);
    en = 1'b1; x = b;
    @(posedge clk); #1;
    en = 1'b0;
    chk(tag, 32'(u), 32'(exp_u));
  endtask

  task automatic idle(input string tag);
    en = 1'b0; x = 1'($urandom);
    @(posedge clk); #1;
    chk(tag, 32'(u), 32'd0);
  endtask

  logic [9:0] s1;
  logic [9:0] u1;
  logic [4:0] s3;

  initial begin
    rst = 1'b1; load = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
    en = 1'b0; x = 1'b0; clear = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_u", 32'(u), 0);
    chk("rst_cnt", 32'(match_count), 0);
    chk("rst_sat", 32'(sat), 0);
    chk("rst_armed", 32'(armed), 0);
    chk("rst_err", 32'(cfg_err), 0);
    rst = 1'b0;
    @(posedge clk); #1;
    // Unarmed after reset: a stream produces nothing.
    send(1'b1, 1'b0, "unarmed_b0");
    send(1'b1, 1'b0, "unarmed_b1");

    // 1: pattern 01011 non-overlapping, first stream bit in s1[9].
    do_load(8'b0000_1011, 4'd5, 1'b0);
    chk("t1_armed", 32'(armed), 1);
    chk("t1_err", 32'(cfg_err), 0);
    s1 = 10'b01011_01011;
    u1 = 10'b00001_00001;
    for (int i = 9; i >= 0; i--) send(s1[i], u1[i], $sformatf("t1_u_bit%0d", 10 - i));
    chk("t1_cnt", 32'(match_count), 2);

    // 2: 101 with and without overlap.
    do_clear();
    chk("t2_clr_cnt", 32'(match_count), 0);
    do_load(8'b1111_1101, 4'd3, 1'b1);
    send(1'b1, 1'b0, "t2o_b1"); send(1'b0, 1'b0, "t2o_b2"); send(1'b1, 1'b1, "t2o_b3");
    send(1'b0, 1'b0, "t2o_b4"); send(1'b1, 1'b1, "t2o_b5");
    chk("t2o_cnt", 32'(match_count), 2);
    do_clear();
    do_load(8'b0000_0101, 4'd3, 1'b0);
    send(1'b1, 1'b0, "t2n_b1"); send(1'b0, 1'b0, "t2n_b2"); send(1'b1, 1'b1, "t2n_b3");
    send(1'b0, 1'b0, "t2n_b4"); send(1'b1, 1'b0, "t2n_b5");
    chk("t2n_cnt", 32'(match_count), 1);

    // 3: 01011 with two idle cycles after every sampled bit.
    do_clear();
    do_load(8'b0000_1011, 4'd5, 1'b0);
    s3 = 5'b01011;
    for (int i = 4; i >= 0; i--) begin
      send(s3[i], (i == 0), $sformatf("t3_u_bit%0d", 5 - i));
      idle($sformatf("t3_idleA_%0d", 5 - i));
      idle($sformatf("t3_idleB_%0d", 5 - i));
    end
    chk("t3_cnt", 32'(match_count), 1);

    // 4: len=1 pattern 1, counter saturation and clear interaction.
    do_clear();
    do_load(8'b1111_1111, 4'd1, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      send(1'b1, 1'b1, $sformatf("t4_u_hit%0d", k));
      chk($sformatf("t4_cnt_hit%0d", k), 32'(match_count), (k > 3) ? 3 : k);
      chk($sformatf("t4_sat_hit%0d", k), 32'(sat), (k >= 4) ? 1 : 0);
    end
    send(1'b0, 1'b0, "t4_u_zero");
    do_clear();
    chk("t4_clr_cnt", 32'(match_count), 0);
    chk("t4_clr_sat", 32'(sat), 0);
    do_load(8'b1111_1111, 4'd1, 1'b0);
    send(1'b1, 1'b1, "t4_pre_hit");
    send(1'b1, 1'b1, "t4_pre_hit2");
    clear = 1'b1;
    send(1'b1, 1'b1, "t4_clrhit_u");
    clear = 1'b0;
    chk("t4_clrhit_cnt", 32'(match_count), 1);
    chk("t4_clrhit_sat", 32'(sat), 0);

    // 5: reload flushes partial history; invalid lengths disarm.
    do_clear();
    do_load(8'b0000_1011, 4'd5, 1'b0);
    send(1'b0, 1'b0, "t5_b1"); send(1'b1, 1'b0, "t5_b2");
    send(1'b0, 1'b0, "t5_b3"); send(1'b1, 1'b0, "t5_b4");
    do_load(8'b0000_1011, 4'd5, 1'b0);
    send(1'b1, 1'b0, "t5_after_reload");
    chk("t5_cnt", 32'(match_count), 0);
    do_load(8'b0000_0001, 4'd0, 1'b1);
    chk("t5_len0_armed", 32'(armed), 0);
    chk("t5_len0_err", 32'(cfg_err), 1);
    for (int k = 0; k < 4; k++) send(1'(k), 1'b0, $sformatf("t5_len0_u%0d", k));
    do_load(8'b0000_0001, 4'd9, 1'b1);
    chk("t5_len9_armed", 32'(armed), 0);
    chk("t5_len9_err", 32'(cfg_err), 1);
    for (int k = 0; k < 4; k++) send(1'b1, 1'b0, $sformatf("t5_len9_u%0d", k));
    chk("t5_bad_cnt", 32'(match_count), 0);

    // 6: asynchronous reset mid-pattern and mid-pulse.
    do_load(8'b0000_0101, 4'd3, 1'b1);
    send(1'b1, 1'b0, "t6_b1"); send(1'b0, 1'b0, "t6_b2");
    #2 rst = 1'b1;
    #1;
    chk("t6_mid_armed", 32'(armed), 0);
    chk("t6_mid_u", 32'(u), 0);
    #1 rst = 1'b0;
    do_load(8'b0000_0101, 4'd3, 1'b1);
    send(1'b1, 1'b0, "t6_c1"); send(1'b0, 1'b0, "t6_c2"); send(1'b1, 1'b1, "t6_c3");
    chk("t6_pre_cnt", 32'(match_count), 1);
    #2 rst = 1'b1;
    #1;
    chk("t6_pulse_u", 32'(u), 0);
    chk("t6_pulse_cnt", 32'(match_count), 0);
    chk("t6_pulse_sat", 32'(sat), 0);
    chk("t6_pulse_armed", 32'(armed), 0);
    #1 rst = 1'b0;
    send(1'b1, 1'b0, "t6_d1"); send(1'b0, 1'b0, "t6_d2"); send(1'b1, 1'b0, "t6_d3");
    do_load(8'b0000_0101, 4'd3, 1'b1);
    send(1'b1, 1'b0, "t6_e1"); send(1'b0, 1'b0, "t6_e2"); send(1'b1, 1'b1, "t6_e3");
    chk("t6_end_cnt", 32'(match_count), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
